// File: rtl/lsu_mem_ctrl_pkg.sv
// lsu_mem_ctrl_pkg: op encodings, bus direction constants, FSM states and op decode helpers for the LSU.
package lsu_mem_ctrl_pkg;
    localparam int DataWidth = 32;
    localparam logic WRITE = 1'b1;
    localparam logic READ = 1'b0;
    localparam logic [3:0] LSU_LB = 4'd0, LSU_LBU = 4'd1, LSU_LH = 4'd2, LSU_LHU = 4'd3, LSU_LW = 4'd4;
    localparam logic [3:0] LSU_SB = 4'd5, LSU_SH = 4'd6, LSU_SW = 4'd7, LSU_LL = 4'd8, LSU_SC = 4'd9;
    typedef enum logic [1:0] {IDLE, ACCESS, RESP, FAULT} state_t;
    typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_t;
    function automatic size_t op_size(input logic [3:0] op);
        return (op inside {LSU_LB, LSU_LBU, LSU_SB}) ? SZ_B : (op inside {LSU_LH, LSU_LHU, LSU_SH}) ? SZ_H : SZ_W;
    endfunction
    function automatic logic misaligned(input logic [3:0] op, input logic [1:0] a);
        return op_size(op) == SZ_H ? a[0] : op_size(op) == SZ_W ? |a : 1'b0;
    endfunction
    function automatic logic is_store(input logic [3:0] op);
        return op inside {LSU_SB, LSU_SH, LSU_SW};
    endfunction
    function automatic logic is_load(input logic [3:0] op);
        return op inside {LSU_LB, LSU_LBU, LSU_LH, LSU_LHU, LSU_LW, LSU_LL};
    endfunction
endpackage

// File: rtl/lsu_mem_ctrl_if.sv
// lsu_mem_ctrl_if: pipeline-to-LSU request/done handshake; master is the MEM stage, slave is the LSU.
interface lsu_mem_ctrl_if #(parameter int DATA_W = 32);
    logic req_i;
    logic [3:0] op_i;
    logic [DATA_W-1:0] addr_i;
    logic [DATA_W-1:0] wdata_i;
    logic flush_i;
    logic done_o;
    logic exc_o;
    logic busy_o;
    logic [DATA_W-1:0] rdata_o;
    modport master(output req_i, op_i, addr_i, wdata_i, flush_i, input done_o, exc_o, busy_o, rdata_o);
    modport slave(input req_i, op_i, addr_i, wdata_i, flush_i, output done_o, exc_o, busy_o, rdata_o);
endinterface

// File: rtl/lsu_mem_ctrl_lane_align.sv
// lsu_lane_align: big-endian byte-lane select, store replication and load extract/extend.
module lsu_lane_align
    import lsu_mem_ctrl_pkg::*;
(
    input  logic [3:0]           op,
    input  logic [1:0]           lane,
    input  logic [DataWidth-1:0] wdata,
    input  logic [DataWidth-1:0] rword,
    output logic [3:0]           sel,
    output logic [DataWidth-1:0] wdata_rep,
    output logic [DataWidth-1:0] rdata_ext
);
    size_t sz;
    logic sgn;
    logic [7:0] b;
    logic [15:0] h;
    always_comb begin
        sz = op_size(op);
        sgn = op == LSU_LB || op == LSU_LH;
        // lane 0 is the most significant byte, hence the inverted shift
        b = 8'(rword >> {~lane, 3'b000});
        h = 16'(rword >> {~lane[1], 4'b0000});
        sel = sz == SZ_W ? 4'b1111 : sz == SZ_H ? (lane[1] ? 4'b0011 : 4'b1100) : 4'b1000 >> lane;
        wdata_rep = sz == SZ_B ? {4{wdata[7:0]}} : sz == SZ_H ? {2{wdata[15:0]}} : wdata;
        rdata_ext = sz == SZ_B ? {{24{sgn & b[7]}}, b} : sz == SZ_H ? {{16{sgn & h[15]}}, h} : rword;
    end
endmodule

// File: rtl/lsu_mem_ctrl.sv
// lsu_mem_ctrl: load/store initiator between MEM stage and byte-lane RAM with misalign faults and LL/SC.
module lsu_mem_ctrl
    import lsu_mem_ctrl_pkg::*;
#(
    parameter int DATA_W = DataWidth,
    parameter logic [DATA_W-1:0] RESET_RDATA = '0
) (
    input  logic              clk,
    input  logic              rst,
    lsu_mem_ctrl_if.slave     pipe,
    output logic              ram_en,
    output logic              wr_en,
    output logic [3:0]        Bits_Sel,
    output logic [DATA_W-1:0] ram_addr_o,
    output logic [DATA_W-1:0] data_to_ram,
    input  logic [DATA_W-1:0] data_from_ram
);
    state_t st;
    logic [3:0] op_q;
    logic [DATA_W-1:0] addr_q, wdata_q, wdata_rep, rdata_ext;
    logic [DATA_W-3:0] ll_addr;
    logic [3:0] sel;
    logic llbit, acc, hit, sc_ok, wr;
    lsu_lane_align u_align (
        .op(op_q), .lane(addr_q[1:0]), .wdata(wdata_q), .rword(data_from_ram),
        .sel(sel), .wdata_rep(wdata_rep), .rdata_ext(rdata_ext)
    );
    always_comb begin
        acc = st == ACCESS;
        hit = ll_addr == addr_q[DATA_W-1:2];
        sc_ok = llbit && hit;
        wr = is_store(op_q) || (op_q == LSU_SC && sc_ok);
        ram_en = acc && !pipe.flush_i;
        wr_en = acc && wr ? WRITE : READ;
        Bits_Sel = acc ? sel : 4'b0000;
        ram_addr_o = acc ? {addr_q[DATA_W-1:2], 2'b00} : '0;
        data_to_ram = acc && (is_store(op_q) || op_q == LSU_SC) ? wdata_rep : '0;
        pipe.done_o = st == RESP && !pipe.flush_i;
        pipe.exc_o = st == FAULT && !pipe.flush_i;
        pipe.busy_o = st != IDLE;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            st <= IDLE;
            op_q <= '0;
            addr_q <= '0;
            wdata_q <= '0;
            llbit <= 1'b0;
            ll_addr <= '0;
            pipe.rdata_o <= RESET_RDATA;
        end else if (pipe.flush_i) begin
            st <= IDLE;
            llbit <= 1'b0;
        end else if (st == IDLE) begin
            if (pipe.req_i) begin
                op_q <= pipe.op_i;
                addr_q <= pipe.addr_i;
                wdata_q <= pipe.wdata_i;
                st <= misaligned(pipe.op_i, pipe.addr_i[1:0]) ? FAULT : ACCESS;
                if (misaligned(pipe.op_i, pipe.addr_i[1:0])) pipe.rdata_o <= RESET_RDATA;
            end
        end else if (acc) begin
            st <= RESP;
            pipe.rdata_o <= is_load(op_q) ? rdata_ext : {{(DATA_W-1){1'b0}}, op_q == LSU_SC && sc_ok};
            // any committed write to the reserved word, including a winning SC, drops the reservation
            if (op_q == LSU_LL) begin
                llbit <= 1'b1;
                ll_addr <= addr_q[DATA_W-1:2];
            end else if (wr && hit) llbit <= 1'b0;
        end else st <= IDLE;
    end
endmodule

// File: doc/lsu_mem_ctrl.md
Name: lsu_mem_ctrl

Overview:
- Load/store initiator sitting between the MEM pipeline stage and the byte-lane data RAM.
- Accepts one memory op per request and produces the RAM-side controls: ram_en, wr_en, 4-bit byte select, word address and write data.
- For loads, it aligns and extends the returned word into a GPR result.
- Adds misalignment detection and an LL/SC reservation bit; the pipeline stalls on it through a request/done handshake.

Parameters:
DATA_W, 32, data and address width (equals `DataWidth)
RESET_RDATA, 0, value of rdata_o after reset and on faults

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
req_i  in  1  pipeline requests a memory op; held stable until done_o or exc_o
op_i  in  4  op code: LB, LBU, LH, LHU, LW, SB, SH, SW, LL, SC (encodings in shared defines)
addr_i  in  32  byte address
wdata_i  in  32  store data (right-justified)
flush_i  in  1  pipeline flush (exception/eret)
done_o  out  1  one-cycle pulse: op complete, rdata_o valid
exc_o  out  1  one-cycle pulse: misaligned address, no RAM access made
busy_o  out  1  FSM not in IDLE
rdata_o  out  32  load result, or SC status (1 = success, 0 = fail)
ram_en  out  1  RAM enable
wr_en  out  1  `WRITE / `READ
Bits_Sel  out  4  byte-lane enables; [3] maps to data[31:24]
ram_addr_o  out  32  byte address, low 2 bits forced to 0
data_to_ram  out  32  lane-replicated store data
data_from_ram  in  32  combinational read data from RAM

Behaviour:
- Clocking and reset:
  - One clock domain. Reset is synchronous and active-high.
  - On reset: FSM = IDLE, llbit = 0, done_o = exc_o = 0, rdata_o = RESET_RDATA.
  - On reset: all RAM outputs are 0, with wr_en = `READ.
- FSM states: IDLE, ACCESS, RESP, FAULT.
- IDLE:
  - When req_i=1 and flush_i=0, latch op, addr and wdata.
  - Misaligned addresses go to FAULT: H-ops with addr[0]≠0, or W/LL/SC with addr[1:0]≠0.
  - All other requests go to ACCESS.
- ACCESS (exactly 1 cycle):
  - ram_en = ~flush_i.
  - wr_en = `WRITE for SB, SH, SW, and for SC when llbit=1 and the LL word address matches; otherwise `READ.
  - Loads register data_from_ram on this edge. Next state is RESP.
- RESP: done_o=1 and rdata_o valid. Next state is IDLE.
- FAULT: exc_o=1, no RAM access. Next state is IDLE.
- Latency: req at cycle N → RAM access at N+1 → done at N+2. Each op uses exactly one RAM cycle.
- RAM outputs are 0 in every state except ACCESS.
- Byte select (big-endian, by addr[1:0]):
  - Byte ops: 00→1000, 01→0100, 10→0010, 11→0001.
  - Half ops: 00→1100, 10→0011.
  - Word ops: 1111.
- Store data: SB replicates wdata[7:0] ×4; SH replicates wdata[15:0] ×2; SW, SC pass wdata straight through.
- Load extraction: select the lane by addr[1:0]. LB/LH sign-extend; LBU/LHU zero-extend; LW/LL pass the full word.
- LL/SC reservation:
  - LL sets llbit=1 and records addr[31:2].
  - A successful SC writes, returns 1 and clears llbit. A failed SC makes no write and returns 0.
  - Any committed store (SB, SH, SW) to the reserved word clears llbit.
  - flush_i clears llbit.
- flush_i:
  - Any state → IDLE on the next edge.
  - In ACCESS it gates ram_en combinationally, so no write commits.
  - done_o and exc_o are suppressed in the flushed cycle.
- Handshake: the pipeline must drop or change req_i in the cycle after done_o or exc_o. A req_i still high in IDLE is taken as a new op.

Decomposition:
- Shared define file holds:
  - the op encodings (`LSU_LB … `LSU_SC);
  - `WRITE/`READ, `DataWidth;
  - FSM state constants.
- One natural sub-module, lsu_lane_align: combinational byte-select, store replication and load extract/extend. It is shared by the ACCESS and RESP logic.

Test Plan:
- SB addr=0x0000_0103, wdata=0x55 → ACCESS: Bits_Sel=0001, data_to_ram=0x5555_5555, ram_addr_o=0x100. Then LB of the same address → rdata_o=0x0000_0055.
- SW 0x8001_F0A5 @0x200, then LH @0x200 → rdata_o=0xFFFF_8001; LHU @0x202 → rdata_o=0x0000_F0A5. done_o asserts 2 cycles after each req.
- LH @0x201 → exc_o pulse at cycle N+1, ram_en stays 0 throughout, no done_o.
- LL @0x300; SC @0x300 wdata=7 → write with Bits_Sel=1111, rdata_o=1. A second SC → no write, rdata_o=0.
- LL @0x300, SW @0x300, SC @0x300 → SC fails, rdata_o=0. Separately: LL, flush_i, SC → SC fails.
- SW req with flush_i asserted during ACCESS → ram_en=0 that cycle, FSM back in IDLE, a later LW returns the old data. rst mid-ACCESS → all outputs 0 on the next cycle.
